// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage between the EX_MEM and MEM_WB registers.
//   Passes ALU results through for non-memory ops. Runs loads and stores against the
//   data RAM over a ready handshake, with byte/half/word lane alignment and load
//   sign/zero extension. Holds the upstream stages with o_stall while an access is
//   outstanding, and reports misalignment, illegal size and RAM timeout on o_memError.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_memReadEnable/WriteEn  load / store request (both high = store)
//   i_memAddr, i_memSel      byte address; size [1:0] and zero-extend flag [2]
//   i_storeValue, i_result   store data; ALU result for non-memory ops
//   i_regDest, i_writeEnable destination register and write request
//   o_regDest, o_value,      writeback information towards MEM_WB
//   o_writeEnable
//   o_ram*                   registered RAM request (enable, write, word address, lanes, data)
//   i_ramRData, i_ramReady   RAM read data and completion
//   o_stall, o_memError      upstream hold (combinational); one-cycle error pulse
module mem_access #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_memReadEnable,
    input  logic        i_memWriteEnable,
    input  logic [31:0] i_memAddr,
    input  logic [2:0]  i_memSel,
    input  logic [31:0] i_storeValue,
    input  logic [31:0] i_result,
    input  logic [4:0]  i_regDest,
    input  logic        i_writeEnable,
    output logic [4:0]  o_regDest,
    output logic [31:0] o_value,
    output logic        o_writeEnable,
    output logic        o_ramEnable,
    output logic        o_ramWrite,
    output logic [31:0] o_ramAddr,
    output logic [3:0]  o_ramByteMask,
    output logic [31:0] o_ramWData,
    input  logic [31:0] i_ramRData,
    input  logic        i_ramReady,
    output logic        o_stall,
    output logic        o_memError
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic [31:0]          rdata_q;

    logic is_mem, misaligned, issue, finish;

    // Byte-lane enables: bit 0 is the lowest byte address (little-endian).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   lane_mask = 4'b0001 << a;
            2'b01:   lane_mask = 4'b0011 << a;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the RAM picks it up whatever the offset.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] v);
        case (size)
            2'b00:   lane_data = {4{v[7:0]}};
            2'b01:   lane_data = {2{v[15:0]}};
            default: lane_data = v;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  a,
                                                 input logic [2:0]  sel);
        logic [31:0] shifted;
        logic        ext;
        shifted = rdata >> {a, 3'b000};
        case (sel[1:0])
            2'b00: begin
                ext          = ~sel[2] & shifted[7];
                load_extract = {{24{ext}}, shifted[7:0]};
            end
            2'b01: begin
                ext          = ~sel[2] & shifted[15];
                load_extract = {{16{ext}}, shifted[15:0]};
            end
            default: load_extract = rdata;
        endcase
    endfunction

    assign is_mem     = i_memReadEnable | i_memWriteEnable;
    assign misaligned = (i_memSel[1:0] == 2'b11) ||
                        (i_memSel[1:0] == 2'b01 && i_memAddr[0]) ||
                        (i_memSel[1:0] == 2'b10 && i_memAddr[1:0] != 2'b00);
    assign o_regDest  = i_regDest;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        o_stall       = 1'b0;
        o_writeEnable = 1'b0;
        o_memError    = 1'b0;
        o_value       = i_result;
        issue         = 1'b0;
        finish        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    o_writeEnable = i_writeEnable;
                end else if (misaligned) begin
                    o_memError = 1'b1;
                end else begin
                    o_stall   = 1'b1;
                    issue     = 1'b1;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                o_stall = 1'b1;
                if (i_ramReady) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                    o_memError = 1'b1;
                    finish     = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                // Unconditional return to IDLE: the op still on the inputs is not reissued.
                state_d = IDLE;
                if (!i_memWriteEnable) begin
                    o_value       = load_extract(rdata_q, i_memAddr[1:0], i_memSel);
                    o_writeEnable = i_writeEnable & ~timeout_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            o_stall       = 1'b0;
            o_writeEnable = 1'b0;
            o_memError    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            rdata_q       <= '0;
            o_ramEnable   <= 1'b0;
            o_ramWrite    <= 1'b0;
            o_ramAddr     <= '0;
            o_ramByteMask <= '0;
            o_ramWData    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            if (issue) begin
                o_ramEnable   <= 1'b1;
                o_ramWrite    <= i_memWriteEnable;
                o_ramAddr     <= {i_memAddr[31:2], 2'b00};
                o_ramByteMask <= lane_mask(i_memSel[1:0], i_memAddr[1:0]);
                o_ramWData    <= lane_data(i_memSel[1:0], i_storeValue);
            end
            if (finish) begin
                o_ramEnable <= 1'b0;
            end
            if (state_q == BUSY && i_ramReady) begin
                rdata_q <= i_ramRData;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_memReadEnable, i_memWriteEnable;
    logic [31:0] i_memAddr;
    logic [2:0]  i_memSel;
    logic [31:0] i_storeValue, i_result;
    logic [4:0]  i_regDest;
    logic        i_writeEnable;
    logic [4:0]  o_regDest;
    logic [31:0] o_value;
    logic        o_writeEnable, o_ramEnable, o_ramWrite;
    logic [31:0] o_ramAddr;
    logic [3:0]  o_ramByteMask;
    logic [31:0] o_ramWData;
    logic [31:0] i_ramRData;
    logic        i_ramReady;
    logic        o_stall, o_memError;

    mem_access #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_memReadEnable(i_memReadEnable), .i_memWriteEnable(i_memWriteEnable),
        .i_memAddr(i_memAddr), .i_memSel(i_memSel), .i_storeValue(i_storeValue),
        .i_result(i_result), .i_regDest(i_regDest), .i_writeEnable(i_writeEnable),
        .o_regDest(o_regDest), .o_value(o_value), .o_writeEnable(o_writeEnable),
        .o_ramEnable(o_ramEnable), .o_ramWrite(o_ramWrite), .o_ramAddr(o_ramAddr),
        .o_ramByteMask(o_ramByteMask), .o_ramWData(o_ramWData),
        .i_ramRData(i_ramRData), .i_ramReady(i_ramReady),
        .o_stall(o_stall), .o_memError(o_memError)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations written by the driver, checked on the falling edge.
    logic        chk_en = 1'b0, chk_ram = 1'b0, chk_fields = 1'b0, chk_val = 1'b0;
    logic        exp_stall, exp_we, exp_err, exp_ramen, exp_ramwr;
    logic [31:0] exp_value, exp_addr, exp_wdata;
    logic [3:0]  exp_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(o_stall), 32'(exp_stall));
            chk("writeEnable", 32'(o_writeEnable), 32'(exp_we));
            chk("memError", 32'(o_memError), 32'(exp_err));
            chk("regDest", 32'(o_regDest), 32'(i_regDest));
            if (chk_ram) chk("ramEnable", 32'(o_ramEnable), 32'(exp_ramen));
            if (chk_fields) begin
                chk("ramWrite", 32'(o_ramWrite), 32'(exp_ramwr));
                chk("ramAddr", o_ramAddr, exp_addr);
                chk("ramByteMask", 32'(o_ramByteMask), 32'(exp_mask));
                chk("ramWData", o_ramWData, exp_wdata);
            end
            if (chk_val) chk("value", o_value, exp_value);
        end
    end

    // ---------------- reference model (transaction level) ----------------
    function automatic logic legal(input logic [31:0] addr, input logic [2:0] sel);
        case (sel[1:0])
            2'd0:    legal = 1'b1;
            2'd1:    legal = (addr % 2) == 0;
            2'd2:    legal = (addr % 4) == 0;
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [2:0] sel);
        longint v;
        int     off;
        off = int'(addr % 4);
        v   = longint'(rdata) / (longint'(1) << (8 * off));
        case (sel[1:0])
            2'd0: begin v = v % 256;   if (!sel[2] && v >= 128)   v = v - 256;   end
            2'd1: begin v = v % 65536; if (!sel[2] && v >= 32768) v = v - 65536; end
            default: v = longint'(rdata);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_mask(input logic [31:0] addr, input logic [2:0] sel);
        int off;
        off = int'(addr % 4);
        case (sel[1:0])
            2'd0:    model_mask = 4'(1 << off);
            2'd1:    model_mask = 4'(3 << off);
            default: model_mask = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] v, input logic [2:0] sel);
        case (sel[1:0])
            2'd0:    model_wdata = (v % 256) * 32'h0101_0101;
            2'd1:    model_wdata = (v % 65536) * 32'h0001_0001;
            default: model_wdata = v;
        endcase
    endfunction

    task automatic set_exp(input logic st, input logic we, input logic er, input logic cr,
                           input logic re, input logic cf, input logic cv, input logic [31:0] v);
        exp_stall = st; exp_we = we; exp_err = er; chk_ram = cr; exp_ramen = re;
        chk_fields = cf; chk_val = cv; exp_value = v; chk_en = 1'b1;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage. lat = BUSY cycle index at which ready is given, -1 = never.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [2:0] sel,
                          input logic [31:0] sv, input logic [31:0] res, input logic [4:0] rdst,
                          input logic wen, input int lat, input logic [31:0] rdv);
        logic        timed_out;
        logic [31:0] cap;
        i_memReadEnable = rd; i_memWriteEnable = wr; i_memAddr = addr; i_memSel = sel;
        i_storeValue = sv; i_result = res; i_regDest = rdst; i_writeEnable = wen;
        i_ramReady = 1'b0; i_ramRData = $urandom;
        if (!rd && !wr) begin
            set_exp(1'b0, wen, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, res);
            next_cycle();
            return;
        end
        if (!legal(addr, sel)) begin
            set_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            next_cycle();
            return;
        end
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        exp_ramwr = wr;
        exp_addr  = addr - (addr % 4);
        exp_mask  = model_mask(addr, sel);
        exp_wdata = model_wdata(sv, sel);
        timed_out = 1'b0;
        cap       = 32'h0;
        for (int k = 0; k < TIMEOUT; k++) begin
            i_ramReady = (k == lat);
            i_ramRData = (k == lat) ? rdv : $urandom;
            if (k == lat) cap = rdv;
            timed_out = (k != lat) && (k == TIMEOUT - 1);
            set_exp(1'b1, 1'b0, timed_out, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            next_cycle();
            if (k == lat || timed_out) break;
        end
        i_ramReady = 1'b0;
        if (wr)
            set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        else
            set_exp(1'b0, wen & ~timed_out, 1'b0, 1'b1, 1'b0, 1'b1, ~timed_out,
                    model_load(cap, addr, sel));
        next_cycle();
    endtask

    initial begin
        int kind, lat;
        logic [2:0]  sel;
        logic [31:0] addr;

        // Pin the model against hand-computed values.
        chk("model_lb_sext", model_load(32'h80FF_0011, 32'h103, 3'b000), 32'hFFFF_FF80);
        chk("model_lbu", model_load(32'h80FF_0011, 32'h103, 3'b100), 32'h0000_0080);
        chk("model_lh_off2", model_load(32'h80FF_0011, 32'h102, 3'b001), 32'hFFFF_80FF);
        chk("model_sh_mask", 32'(model_mask(32'h202, 3'b001)), 32'h0000_000C);
        chk("model_sh_wdata", model_wdata(32'h0000_ABCD, 3'b001), 32'hABCD_ABCD);
        chk("model_sb_wdata", model_wdata(32'h1234_5678, 3'b000), 32'h7878_7878);

        // Reset: outputs gated even with a write request on the inputs.
        rst = 1'b1;
        i_memReadEnable = 1'b0; i_memWriteEnable = 1'b0; i_memAddr = '0; i_memSel = '0;
        i_storeValue = '0; i_result = 32'h55; i_regDest = 5'd3; i_writeEnable = 1'b1;
        i_ramRData = '0; i_ramReady = 1'b0;
        next_cycle();
        exp_ramwr = 1'b0; exp_addr = '0; exp_mask = '0; exp_wdata = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Directed cases.
        run_op(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h1234, 5'd5, 1'b1, 0, 32'h0);
        run_op(1'b1, 1'b0, 32'h103, 3'b000, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h80FF_0011);
        run_op(1'b1, 1'b0, 32'h103, 3'b100, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h80FF_0011);
        run_op(1'b0, 1'b1, 32'h202, 3'b001, 32'h0000_ABCD, 32'h0, 5'd0, 1'b0, 1, 32'h0);
        run_op(1'b1, 1'b0, 32'h6, 3'b010, 32'h0, 32'h0, 5'd7, 1'b1, 0, 32'h0);
        run_op(1'b1, 1'b0, 32'h40, 3'b010, 32'h0, 32'h0, 5'd8, 1'b1, -1, 32'h0);
        run_op(1'b1, 1'b1, 32'h44, 3'b010, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1, 2, 32'h0);

        // Reset while BUSY: access abandoned, no writeback afterwards.
        i_memReadEnable = 1'b1; i_memWriteEnable = 1'b0; i_memAddr = 32'h80; i_memSel = 3'b010;
        i_regDest = 5'd10; i_writeEnable = 1'b1; i_ramReady = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        rst = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        rst = 1'b0;
        i_memReadEnable = 1'b0; i_writeEnable = 1'b0; i_result = 32'h77;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77);
        next_cycle();

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            sel  = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ((sel[1:0] == 2'd2) ? 32'hFFFF_FFFC :
                                                          (sel[1:0] == 2'd1) ? 32'hFFFF_FFFE : addr);
            lat = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
            if (kind < 3)
                run_op(1'b0, 1'b0, addr, sel, $urandom, $urandom, 5'($urandom), 1'($urandom), lat, $urandom);
            else
                run_op(kind < 6, kind >= 6 || kind == 5 && sel[2], addr, sel, $urandom, $urandom,
                       5'($urandom), 1'($urandom), lat, $urandom);
        end

        chk_en = 1'b0;
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
